adder_test_ctrl_r4: RTL and testbench
=====================================

# adder_test_ctrl_r4

Self-checking sequencer for the radix-4 online adder test bench. Steps through the built-in test-vector set by driving the vector ROM's select input. For each test it feeds operand digits serially, MSB first, into the online adder, captures the N+1 result digits and compares them with the expected result. It reports one ASCII pass/fail byte per test over a byte-stream handshake to the UART transmitter.

## Interface
- N, 6, digits per operand
- C, 3, bits per digit (two's-complement signed digit, range -3..3)
- DELTA, 2, online delay of the adder in digits
- NUM_TESTS, 8, tests run per pass (1..11)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset
- start  in  1  begin a full pass; sampled only in IDLE
- test_select  out  10  vector ROM select
- x_vec  in  N*C  first operand from ROM, digit N-1 in MSBs
- y_vec  in  N*C  second operand from ROM
- z_vec  in  (N+1)*C  expected sum from ROM, digit N in MSBs
- add_clr  out  1  synchronous clear of adder state
- add_en  out  1  adder consumes add_x/add_y this cycle
- add_x  out  C  serial x digit
- add_y  out  C  serial y digit
- add_z  in  C  serial result digit; registered, one cycle after the consuming edge
- tx_data  out  8  report byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts byte
- busy  out  1  high in every state except IDLE/DONE
- done  out  1  high in DONE
- pass_mask  out  NUM_TESTS  bit k set when test k passed
- all_pass  out  1  done & (&pass_mask)

## Operation
- Reset values: every output is 0. State is IDLE and test index k is 0.
- Test k selection: k=0 gives test_select=0; k≥1 gives test_select=1<<(k-1). test_select holds its value from SELECT through REPORT.
- FSM states and transitions:
  - IDLE -> SELECT on start. start is ignored in every other state except DONE.
  - SELECT (1 cycle): at its end, latch x_vec, y_vec and z_vec into shadow registers.
  - CLEAR (1 cycle): add_clr=1, add_en=0.
  - FEED (F=N+1+DELTA cycles, t=0..F-1): add_en=1.
    - For t<N: add_x = shadow x digit N-1-t; likewise add_y.
    - For t≥N: add_x = add_y = 0.
  - DRAIN (1 cycle): add_en=0, add_x=add_y=0.
  - CHECK (1 cycle): compare the captured (N+1)*C vector with shadow z; result goes to pass_mask[k].
  - REPORT: tx_valid=1. tx_data=8'h50 ('P') on pass, 8'h46 ('F') on fail. Hold until the handshake.
  - After REPORT: if k<NUM_TESTS-1, increment k and go to SELECT; otherwise go to DONE.
  - DONE: done=1; test_select, pass_mask and all_pass hold. start -> SELECT with k=0 and pass_mask cleared.
- Capture: add_z is sampled at the end of cycles DELTA+1..F, counted from FEED cycle 0, with cycle F being DRAIN.
  - That is N+1 digits, MSB first, shifted into the capture register from the LSB end.
  - The first captured digit ends up in the MSB position.
- Digit comparison is bitwise on C-bit fields; no redundant-value equivalence is applied.
- Shadow registers isolate the comparison from ROM changes during a test.

## Timing
- Transfer rule: a byte transfers on an edge where tx_valid & tx_ready. tx_data and tx_valid stay stable until that edge, and tx_valid drops the next cycle.
- Per-test cycles with tx_ready=1: SELECT 1 + CLEAR 1 + FEED F + DRAIN 1 + CHECK 1 + REPORT 1 = F+5. This is 14 with the defaults.
- Full pass with defaults and no backpressure: done rises 112 cycles after the edge that samples start.
- Backpressure: each cycle of tx_ready=0 during REPORT adds exactly one cycle. No other state waits.
- pass_mask[k] updates at the end of CHECK and is visible during REPORT.
- Reset in any state, including mid-FEED or mid-REPORT, takes effect at the next edge. All outputs return to 0 and any in-flight test is abandoned.
- The last test (k=NUM_TESTS-1) takes the DONE transition. Test index k never wraps.
- start held high across DONE->SELECT starts exactly one new pass.

## Test plan
- Defaults, ideal behavioural adder, tx_ready=1, pulse start -> bytes "PPPPPPPP" in order; pass_mask=8'hFF, done and all_pass high 112 cycles after start, busy low.
- Adder model inverting result digit 2 for test_select=10'b0000000100 (test 3) -> 4th byte 8'h46, all others 8'h50; pass_mask=8'hF7, all_pass=0.
- Check test 1 (test_select=10'b0000000001) -> add_x sequence 1,2,5,3,0,7,0,0,0 and add_y sequence 2,7,5,3,2,2,0,0,0 on consecutive add_en cycles. add_clr pulses exactly once, immediately before the first add_en.
- tx_ready low for 5 cycles on entering each REPORT -> tx_data/tx_valid stable throughout; done at cycle 152; results identical to the first scenario.
- start pulsed during FEED -> ignored. reset asserted mid-FEED of test 4 -> next cycle all outputs 0, IDLE. A new start reruns from test 0 with test_select=0.
- Second start from DONE after a failing pass -> pass_mask cleared at SELECT; full pass repeats with correct bytes.

Source files
------------

// File: rtl/adder_test_ctrl_r4_if.sv
// Byte-stream handshake from the test sequencer to the report transmitter.
// A byte moves on every rising edge where tx_valid and tx_ready are both high.
interface adder_test_ctrl_r4_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/adder_test_ctrl_r4.sv
// Self-checking sequencer for the radix-4 online adder: feeds ROM operands MSB first,
// captures the N+1 result digits, compares with the expected sum and reports 'P'/'F'.
module adder_test_ctrl_r4 #(
  parameter int N         = 6,
  parameter int C         = 3,
  parameter int DELTA     = 2,
  parameter int NUM_TESTS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [9:0]           test_select,
  input  logic [N*C-1:0]       x_vec,
  input  logic [N*C-1:0]       y_vec,
  input  logic [(N+1)*C-1:0]   z_vec,
  output logic                 add_clr,
  output logic                 add_en,
  output logic [C-1:0]         add_x,
  output logic [C-1:0]         add_y,
  input  logic [C-1:0]         add_z,
  adder_test_ctrl_r4_if.master tx,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_TESTS-1:0] pass_mask,
  output logic                 all_pass
);
  localparam int F  = N + 1 + DELTA;
  localparam int TW = $clog2(F + 1);
  localparam int KW = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1;
  localparam int XW = N * C;
  localparam int ZW = (N + 1) * C;
  localparam logic [TW-1:0] T_LAST = TW'(F - 1);
  localparam logic [TW-1:0] T_CAP  = TW'(DELTA + 1);
  localparam logic [KW-1:0] K_LAST = KW'(NUM_TESTS - 1);
  localparam logic [7:0]    CH_P   = 8'h50;
  localparam logic [7:0]    CH_F   = 8'h46;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_CLEAR  = 3'd2;
  localparam logic [2:0] S_FEED   = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_CHECK  = 3'd5;
  localparam logic [2:0] S_REPORT = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  logic [2:0]           state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [TW-1:0]        t_q, t_d;
  logic [XW-1:0]        x_sh_q, x_sh_d, y_sh_q, y_sh_d;
  logic [ZW-1:0]        z_sh_q, z_sh_d, cap_q, cap_d;
  logic [NUM_TESTS-1:0] mask_q, mask_d;
  logic [9:0]           sel_q, sel_d;
  logic                 clr_q, clr_d, en_q, en_d;
  logic [C-1:0]         x_q, x_d, y_q, y_d;
  logic [7:0]           txd_q, txd_d;
  logic                 txv_q, txv_d, busy_q, busy_d, done_q, done_d, allp_q, allp_d;
  logic                 match_s;

  // Operand digit presented at feed step t; zero once all N digits are out.
  function automatic logic [C-1:0] feed_digit(input logic [XW-1:0] v, input logic [TW-1:0] t);
    logic [C-1:0] d;
    d = '0;
    for (int i = 0; i < N; i++) begin
      if (t == TW'(N - 1 - i)) d = v[i*C +: C];
    end
    return d;
  endfunction

  function automatic logic [9:0] sel_of(input logic [KW-1:0] kk);
    logic [9:0] s;
    s = 10'd0;
    if (kk != '0) s = 10'd1 << (kk - KW'(1));
    return s;
  endfunction

  assign match_s = (cap_q == z_sh_q);

  // Next-state and next-output decode; outputs are registered for the state being entered.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    t_d     = t_q;
    x_sh_d  = x_sh_q;
    y_sh_d  = y_sh_q;
    z_sh_d  = z_sh_q;
    cap_d   = cap_q;
    mask_d  = mask_q;
    sel_d   = sel_q;
    clr_d   = 1'b0;
    en_d    = 1'b0;
    x_d     = '0;
    y_d     = '0;
    txd_d   = txd_q;
    txv_d   = 1'b0;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SELECT;
          k_d     = '0;
          sel_d   = 10'd0;
          mask_d  = '0;
        end else begin
          busy_d  = 1'b0;
        end
      end
      S_SELECT: begin
        x_sh_d  = x_vec;
        y_sh_d  = y_vec;
        z_sh_d  = z_vec;
        clr_d   = 1'b1;
        state_d = S_CLEAR;
      end
      S_CLEAR: begin
        state_d = S_FEED;
        t_d     = '0;
        cap_d   = '0;
        en_d    = 1'b1;
        x_d     = feed_digit(x_sh_q, '0);
        y_d     = feed_digit(y_sh_q, '0);
      end
      S_FEED: begin
        // The adder's result lags its inputs, so capture starts DELTA+1 steps in.
        if (t_q >= T_CAP) begin
          cap_d = {cap_q[ZW-C-1:0], add_z};
        end else begin
          cap_d = cap_q;
        end
        if (t_q == T_LAST) begin
          state_d = S_DRAIN;
        end else begin
          t_d  = t_q + TW'(1);
          en_d = 1'b1;
          x_d  = feed_digit(x_sh_q, t_q + TW'(1));
          y_d  = feed_digit(y_sh_q, t_q + TW'(1));
        end
      end
      S_DRAIN: begin
        cap_d   = {cap_q[ZW-C-1:0], add_z};
        state_d = S_CHECK;
      end
      S_CHECK: begin
        mask_d[k_q] = match_s;
        txv_d       = 1'b1;
        txd_d       = match_s ? CH_P : CH_F;
        state_d     = S_REPORT;
      end
      S_REPORT: begin
        if (tx.tx_ready) begin
          if (k_q == K_LAST) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            k_d     = k_q + KW'(1);
            sel_d   = sel_of(k_q + KW'(1));
            state_d = S_SELECT;
          end
        end else begin
          txv_d = 1'b1;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d = S_SELECT;
          k_d     = '0;
          sel_d   = 10'd0;
          mask_d  = '0;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
    allp_d = done_d & (&mask_d);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      t_q     <= '0;
      x_sh_q  <= '0;
      y_sh_q  <= '0;
      z_sh_q  <= '0;
      cap_q   <= '0;
      mask_q  <= '0;
      sel_q   <= '0;
      clr_q   <= 1'b0;
      en_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      txd_q   <= '0;
      txv_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      allp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      t_q     <= t_d;
      x_sh_q  <= x_sh_d;
      y_sh_q  <= y_sh_d;
      z_sh_q  <= z_sh_d;
      cap_q   <= cap_d;
      mask_q  <= mask_d;
      sel_q   <= sel_d;
      clr_q   <= clr_d;
      en_q    <= en_d;
      x_q     <= x_d;
      y_q     <= y_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      allp_q  <= allp_d;
    end
  end

  assign test_select = sel_q;
  assign add_clr     = clr_q;
  assign add_en      = en_q;
  assign add_x       = x_q;
  assign add_y       = y_q;
  assign tx.tx_data  = txd_q;
  assign tx.tx_valid = txv_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass_mask   = mask_q;
  assign all_pass    = allp_q;
endmodule

// File: tb/tb_adder_test_ctrl_r4.sv
// Bench for adder_test_ctrl_r4: random ROM vectors, a digit-serial radix-4 online adder
// model, byte monitor with backpressure, and full-pass / reset / restart scenarios.
module tb_adder_test_ctrl_r4;
  localparam int N = 6, C = 3, DELTA = 2, NT = 8;

  logic clk = 1'b0;
  logic reset, start;
  logic [9:0] test_select;
  logic [N*C-1:0] x_vec, y_vec;
  logic [(N+1)*C-1:0] z_vec;
  logic add_clr, add_en, busy, done, all_pass;
  logic [C-1:0] add_x, add_y, add_z;
  logic [NT-1:0] pass_mask;

  adder_test_ctrl_r4_if tx_if ();

  adder_test_ctrl_r4 #(.N(N), .C(C), .DELTA(DELTA), .NUM_TESTS(NT)) dut (
    .clk(clk), .reset(reset), .start(start), .test_select(test_select),
    .x_vec(x_vec), .y_vec(y_vec), .z_vec(z_vec),
    .add_clr(add_clr), .add_en(add_en), .add_x(add_x), .add_y(add_y), .add_z(add_z),
    .tx(tx_if), .busy(busy), .done(done), .pass_mask(pass_mask), .all_pass(all_pass)
  );

  always #5 clk = ~clk;

  int n_total = 0, n_bad = 0;
  bit fault_en = 1'b0, bp_mode = 1'b0;
  logic [N*C-1:0] rom_x [0:10];
  logic [N*C-1:0] rom_y [0:10];
  logic [(N+1)*C-1:0] rom_z [0:10];
  logic [7:0] rx_q [$];
  logic [C-1:0] fx_q [$];
  logic [C-1:0] fy_q [$];
  int clr_cnt = 0;
  int xd [N];
  int yd [N];
  int pp [N];
  int t1x [N] = '{1, 2, -3, 3, 0, -1};
  int t1y [N] = '{2, -1, -3, 3, 2, 2};
  logic [C-1:0] ex [9] = '{3'd1, 3'd2, 3'd5, 3'd3, 3'd0, 3'd7, 3'd0, 3'd0, 3'd0};
  logic [C-1:0] ey [9] = '{3'd2, 3'd7, 3'd5, 3'd3, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Transfer digit and residual of one position-sum p in [-6,6]
  function automatic int tr(input int p);
    if (p >= 2) return 1;
    else if (p <= -2) return -1;
    else return 0;
  endfunction
  function automatic int wd(input int p);
    return p - 4 * tr(p);
  endfunction
  function automatic int sd(input logic [C-1:0] d);
    return int'($signed(d));
  endfunction
  function automatic bit exp_pass(input int i);
    return !(fault_en && i == 3);
  endfunction

  // Vector ROM: test_select one-hot bit b selects test b+1, zero selects test 0
  always_comb begin
    int idx;
    idx = 0;
    for (int b = 0; b < 10; b++) if (test_select[b]) idx = b + 1;
    x_vec = rom_x[idx];
    y_vec = rom_y[idx];
    z_vec = rom_z[idx];
  end

  // Online adder model: result digit m (MSB first) registered after input step m+DELTA
  initial begin
    int ph [0:15];
    int cnt, m, s;
    logic [C-1:0] pend;
    cnt = 0; pend = '0; add_z = '0;
    forever begin
      @(negedge clk);
      add_z = pend;
      if (add_clr) begin
        cnt = 0; pend = '0;
      end else if (add_en && cnt < 16) begin
        ph[cnt] = sd(add_x) + sd(add_y);
        if (cnt >= DELTA && cnt - DELTA <= N) begin
          m = cnt - DELTA;
          s = (m == 0) ? tr(ph[0]) : wd(ph[m-1]) + tr(ph[m]);
          pend = C'(s);
          if (fault_en && test_select == 10'b0000000100 && N - m == 2) pend = ~pend;
        end
        cnt++;
      end
    end
  end

  // Transmitter side: records transfers, checks hold/drop rules, applies backpressure
  initial begin
    logic pv, pr;
    logic [7:0] pd;
    int bp;
    pv = 1'b0; pr = 1'b0; pd = '0; bp = 0; tx_if.tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (pv && pr) begin
        rx_q.push_back(pd);
        chk("valid_drop", tx_if.tx_valid, 0);
      end else if (pv) begin
        chk("hold_valid", tx_if.tx_valid, 1);
        chk("hold_data", tx_if.tx_data, pd);
      end
      if (tx_if.tx_valid && !pv && rx_q.size() < NT)
        chk("mask_in_report", pass_mask[rx_q.size()], exp_pass(rx_q.size()));
      if (!bp_mode) tx_if.tx_ready = 1'b1;
      else if (!tx_if.tx_valid) begin bp = 0; tx_if.tx_ready = 1'b0; end
      else if (bp < 5) begin bp++; tx_if.tx_ready = 1'b0; end
      else tx_if.tx_ready = 1'b1;
      pv = tx_if.tx_valid; pr = tx_if.tx_ready; pd = tx_if.tx_data;
    end
  end

  // Adder-side monitor: test-1 feed digits and clear/enable ordering
  initial begin
    logic pc;
    pc = 1'b0;
    forever begin
      @(negedge clk);
      if (add_en && test_select == 10'd1) begin
        fx_q.push_back(add_x); fy_q.push_back(add_y);
      end
      if (add_clr) clr_cnt++;
      if (pc) chk("en_after_clr", add_en, 1);
      pc = add_clr;
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_sel"}, test_select, 0);
    chk({tag, "_misc"}, {add_clr, add_en, add_x, add_y, tx_if.tx_valid, busy, done, all_pass, pass_mask}, 0);
    chk({tag, "_txd"}, tx_if.tx_data, 0);
  endtask

  task automatic run_pass(input int exp_cyc, input bit inj);
    int cnt;
    logic [NT-1:0] em;
    rx_q.delete(); fx_q.delete(); fy_q.delete(); clr_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (!done && cnt < 2000) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        chk("sel_first", test_select, 0);
        chk("mask_clr", pass_mask, 0);
        chk("busy_run", busy, 1);
      end
      start = (inj && cnt == 20);
    end
    chk("done_in_time", (cnt < 2000), 1);
    chk("done_cycle", cnt, exp_cyc);
    @(negedge clk);
    em = '0;
    for (int i = 0; i < NT; i++) em[i] = exp_pass(i);
    chk("byte_count", rx_q.size(), NT);
    for (int i = 0; i < NT && i < rx_q.size(); i++)
      chk("byte", rx_q[i], exp_pass(i) ? 8'h50 : 8'h46);
    chk("mask_final", pass_mask, em);
    chk("all_pass", all_pass, &em);
    chk("busy_done", busy, 0);
    chk("done_hold", done, 1);
    chk("clr_pulses", clr_cnt, NT);
    chk("feed_len", fx_q.size(), 9);
    for (int i = 0; i < 9 && i < fx_q.size(); i++) begin
      chk("feed_x", fx_q[i], ex[i]);
      chk("feed_y", fy_q[i], ey[i]);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, s;
    reset = 1'b1; start = 1'b0;
    for (int k = 0; k < 11; k++) begin
      for (int j = 0; j < N; j++) begin
        if (k == 1) begin xd[j] = t1x[j]; yd[j] = t1y[j]; end
        else begin
          xd[j] = int'($urandom_range(6, 0)) - 3;
          yd[j] = int'($urandom_range(6, 0)) - 3;
        end
        rom_x[k][(N-1-j)*C +: C] = C'(xd[j]);
        rom_y[k][(N-1-j)*C +: C] = C'(yd[j]);
      end
      for (int i = 0; i < N; i++) pp[i] = xd[N-1-i] + yd[N-1-i];
      for (int i = 0; i <= N; i++) begin
        s = ((i < N) ? wd(pp[i]) : 0) + ((i > 0) ? tr(pp[i-1]) : 0);
        rom_z[k][i*C +: C] = C'(s);
      end
    end
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    run_pass(112, 1'b1);
    fault_en = 1'b1;
    run_pass(112, 1'b0);
    fault_en = 1'b0;
    bp_mode = 1'b1;
    run_pass(152, 1'b0);
    bp_mode = 1'b0;

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (!(test_select == 10'd8 && add_en) && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    chk("reach_feed4", (cnt < 500), 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero("midreset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_after_rst", {busy, done}, 0);
    run_pass(112, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
